// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchronised, counter-qualified switch debouncer
//
// Purpose: conditions a raw mechanical switch level into a clean registered
// level with one-cycle press/release events and a wrapping press counter.
//
// Ports:
//   i_clk          system clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset of all state
//   i_d            raw switch level, asynchronous to i_clk
//   o_q            debounced switch level (state bit 0)
//   o_press        one-cycle pulse when o_q goes 0->1
//   o_release      one-cycle pulse when o_q goes 1->0
//   o_press_count  accepted presses modulo 256
module switch_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_d,
  output logic       o_q,
  output logic       o_press,
  output logic       o_release,
  output logic [7:0] o_press_count
);

  // Bit 0 of the encoding is the debounced level, so o_q is a direct register bit.
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    HIGH_STABLE = 2'b01,
    LOW_ARMING  = 2'b10,
    HIGH_ARMING = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_press;
  logic                 r_release;
  logic [7:0]           r_press_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_state       <= LOW_STABLE;
      r_cnt         <= LP_ZERO;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_s1      <= i_d;
      r_s2      <= r_s1;
      // Pulses are high only in the cycle following the accepting edge.
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        LOW_STABLE: begin
          if (r_s2) begin
            // A single-cycle requirement accepts on the first disagreeing sample.
            if (STABLE_CYCLES == 1) begin
              r_state       <= HIGH_STABLE;
              r_cnt         <= LP_ZERO;
              r_press       <= 1'b1;
              r_press_count <= r_press_count + 8'd1;
            end else begin
              r_state <= LOW_ARMING;
              r_cnt   <= LP_ONE;
            end
          end
        end
        LOW_ARMING: begin
          if (!r_s2) begin
            r_state <= LOW_STABLE;
            r_cnt   <= LP_ZERO;
          end else if (r_cnt == LP_LAST) begin
            r_state       <= HIGH_STABLE;
            r_cnt         <= LP_ZERO;
            r_press       <= 1'b1;
            r_press_count <= r_press_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        HIGH_STABLE: begin
          if (!r_s2) begin
            if (STABLE_CYCLES == 1) begin
              r_state   <= LOW_STABLE;
              r_cnt     <= LP_ZERO;
              r_release <= 1'b1;
            end else begin
              r_state <= HIGH_ARMING;
              r_cnt   <= LP_ONE;
            end
          end
        end
        HIGH_ARMING: begin
          if (r_s2) begin
            r_state <= HIGH_STABLE;
            r_cnt   <= LP_ZERO;
          end else if (r_cnt == LP_LAST) begin
            r_state   <= LOW_STABLE;
            r_cnt     <= LP_ZERO;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        default: begin
          r_state <= LOW_STABLE;
          r_cnt   <= LP_ZERO;
        end
      endcase
    end
  end

  assign o_q           = r_state[0];
  assign o_press       = r_press;
  assign o_release     = r_release;
  assign o_press_count = r_press_count;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d   = 1'b0;
  logic       q;
  logic       press;
  logic       rel;
  logic [7:0] press_count;

  switch_debounce #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_d           (d),
    .o_q           (q),
    .o_press       (press),
    .o_release     (rel),
    .o_press_count (press_count)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_press;
    logic [7:0] cnt;
    int         at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_cnt = 8'd0;
  bit   prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Advance across n rising edges, landing mid-low-phase.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #5;
  endtask

  task automatic push(input bit is_press);
    exp_t e;
    e.is_press = is_press;
    e.cnt      = exp_cnt;
    e.at_cyc   = cyc + 6;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v);
    d = v;
    if (v) exp_cnt = exp_cnt + 8'd1;
    push(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, {31'd0, q}, 32'd0);
    chk({tag, "_press"}, {31'd0, press}, 32'd0);
    chk({tag, "_release"}, {31'd0, rel}, 32'd0);
    chk({tag, "_count"}, {24'd0, press_count}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    tick(2);
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // Monitor: pops an expectation whenever a pulse is presented.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (prev_pulse) begin
        total++;
        if (press || rel) begin
          bad++;
          $display("FAIL pulse_width actual=%b%b expected=00 cyc=%0d", press, rel, cyc);
        end
      end
      if (press || rel) begin
        total++;
        if (press && rel) begin
          bad++;
          $display("FAIL pulse_overlap actual=11 expected=one-hot cyc=%0d", cyc);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse press=%b release=%b count=%0d cyc=%0d", press, rel, press_count, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (press !== e.is_press || rel !== !e.is_press || q !== e.is_press ||
              press_count !== e.cnt || cyc != e.at_cyc) begin
            bad++;
            $display("FAIL event actual press=%b q=%b count=%0d cyc=%0d expected press=%b q=%b count=%0d cyc=%0d",
                     press, q, press_count, cyc, e.is_press, e.is_press, e.cnt, e.at_cyc);
          end
        end
      end
      prev_pulse = press || rel;
    end
  end

  initial begin
    // Reset with D held high: outputs clear, then a press after full latency.
    #1;
    rst = 1'b1;
    d   = 1'b1;
    #2;
    chk_zero("rst_during");
    #12;
    rst = 1'b0;
    exp_cnt = 8'd1;
    push(1'b1);
    #1;
    chk_zero("rst_after");
    @(negedge clk);
    chk_zero("rst_negedge");
    #5;
    tick(8);
    drive(1'b0);
    tick(8);

    // Clean press from a fresh reset.
    do_reset("rst2");
    tick(2);
    drive(1'b1);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("clean_q_low", {31'd0, q}, 32'd0);
    end
    tick(1);
    chk("clean_q_high", {31'd0, q}, 32'd1);
    chk("clean_press", {31'd0, press}, 32'd1);
    chk("clean_count", {24'd0, press_count}, 32'd1);
    tick(1);
    chk("clean_press_end", {31'd0, press}, 32'd0);
    chk("clean_release", {31'd0, rel}, 32'd0);
    tick(6);
    drive(1'b0);
    tick(8);

    // Glitch of three cycles is rejected.
    d = 1'b1;
    tick(3);
    d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch_q", {31'd0, q}, 32'd0);
      chk("glitch_count", {24'd0, press_count}, {24'd0, exp_cnt});
    end

    // Bounce 1,0,1,0 then settle high.
    d = 1'b1; tick(1);
    d = 1'b0; tick(1);
    d = 1'b1; tick(1);
    d = 1'b0; tick(1);
    drive(1'b1);
    tick(8);
    chk("bounce_count", {24'd0, press_count}, 32'd2);
    drive(1'b0);
    tick(8);

    // Reset in the middle of arming with D held high.
    d = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    tick(2);
    rst = 1'b0;
    exp_cnt = 8'd1;
    push(1'b1);
    tick(8);
    drive(1'b0);
    tick(8);

    // 256 press/release pairs: wrap of the press counter.
    do_reset("rst3");
    tick(2);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1);
      tick(8);
      drive(1'b0);
      tick(8);
      if (i == 254) chk("count_255", {24'd0, press_count}, 32'd255);
    end
    chk("count_wrap", {24'd0, press_count}, 32'd0);

    tick(10);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Reader-side conditioner for a raw mechanical switch input. It samples the asynchronous switch level `D` and synchronises it into `clk`. It accepts a new level only after that level has been stable for `STABLE_CYCLES` consecutive cycles, then reports the clean level `Q`, one-cycle `press`/`release` events and a wrapping press counter. It sits between the board-level switch pins and any logic that consumes switch state, including the `DSwitch` register stage.

## Interface
- `STABLE_CYCLES`, default 4: consecutive disagreeing cycles required to accept a new level; legal range 1..255.
- `CNT_WIDTH`, default 8: width of the internal stability counter; must satisfy 2^CNT_WIDTH > STABLE_CYCLES.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset of all state, including the synchroniser flops.
- `D`  input  1  raw switch level, asynchronous to `clk`.
- `Q`  output  1  debounced, registered switch level.
- `press`  output  1  one-cycle pulse, high in the cycle `Q` goes 0->1.
- `release`  output  1  one-cycle pulse, high in the cycle `Q` goes 1->0.
- `press_count`  output  8  number of accepted presses, modulo 256.

## Operation
- Synchroniser: two flops, `s1 <= D` and `s2 <= s1`. Only `s2` is used downstream.
- The FSM has 4 states. `Q` equals state bit 0.
  - LOW_STABLE: Q=0. If s2=1, go to LOW_ARMING with cnt=1; if STABLE_CYCLES=1, go directly to HIGH_STABLE.
  - LOW_ARMING: Q=0. If s2=0, go to LOW_STABLE with cnt=0 (glitch rejected). If s2=1 and cnt=STABLE_CYCLES-1, go to HIGH_STABLE with cnt=0. Otherwise cnt++.
  - HIGH_STABLE and HIGH_ARMING mirror the two states above with the level inverted.
- Accepted transitions:
  - LOW->HIGH acceptance registers `press`=1 for exactly one cycle and increments `press_count`. The count wraps 255->0.
  - HIGH->LOW acceptance registers `release`=1 for exactly one cycle; `press_count` is unchanged.
- `press` and `release` are never high in the same cycle. Neither pulse is ever high for two consecutive cycles when STABLE_CYCLES>=2.
- Arithmetic:
  - cnt is unsigned CNT_WIDTH and never exceeds STABLE_CYCLES-1.
  - press_count is an unsigned 8-bit increment with no saturation.
- Reset, asserted at any time including mid-arming:
  - s1=s2=0, state LOW_STABLE, cnt=0, Q=0, press=0, release=0, press_count=0, immediately and without waiting for a clock.
  - If D=1 is held through reset, Q rises only after the full latency measured from the first edge after reset deasserts. No pulse is generated during reset.

## Timing
- Reset values of all outputs: Q=0, press=0, release=0, press_count=0.
- Latency: let edge 0 be the first rising edge that samples the new D level into s1. `Q`, the pulse output and `press_count` update together at edge STABLE_CYCLES+1.
  - Default STABLE_CYCLES=4: the update occurs at edge 5, which is 100 ns at CLK_PERIOD=20.
- A level of s2 lasting fewer than STABLE_CYCLES cycles is rejected: it causes no Q change and no pulse, and cnt returns to 0.
- Outputs never change on the falling edge of clk.
- The pulse is high from the accepting edge to the next rising edge.
- D transitions near an edge may resolve one cycle late. Testbenches change D only mid-low-phase.

## Test plan
Every scenario uses STABLE_CYCLES=4 and CLK_PERIOD=20.

- **Reset.** Assert reset with D=1 for half a period, then deassert. Required: Q=0, press=0, release=0, press_count=0 both during and immediately after reset, and also checked a quarter period later on the falling edge.
- **Clean press.** Drive D 0->1 and hold. Required: Q stays 0 through edge 4; at edge 5 Q=1, press=1 for one cycle and press_count=1; release remains 0.
- **Glitch rejection.** From Q=0, drive D=1 for 3 cycles then back to 0. Required: Q, press and press_count are unchanged for 10 cycles.
- **Bounce then settle.** Drive D with the pattern 1,0,1,0 at one cycle each, then hold 1. Required: exactly one press pulse, at edge 5 counted from the first edge that samples the final stable 1; press_count=1.
- **Release and wrap.** Perform 256 press/release pairs, each level held 8 cycles. Required:
  - every release pulse is exactly one cycle long;
  - press and release are never high together;
  - press_count reads 255 after the 255th pair and wraps to 0 on the 256th press.
- **Reset mid-arming.** Drive D=1 and assert reset after edge 3. Required: all outputs are 0 asynchronously. After deassert with D still 1, Q rises at edge 5 measured from the first edge after deassert.
